// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M sequencer: funct3 op codes, ALU function codes,
// FSM state encoding and small op-decode helpers.
package muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 6;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PREP_A = 3'd1;
  localparam logic [2:0] S_PREP_B = 3'd2;
  localparam logic [2:0] S_LOOP   = 3'd3;
  localparam logic [2:0] S_FIX    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  function automatic logic rs1_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_mulhi(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Execute-stage request/result and shared-ALU port bundle for muldiv_seq.
interface muldiv_seq_if;
  import muldiv_pkg::*;

  logic            start;
  logic            kill;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            alu_req;
  logic            alu_gnt;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_fn;
  logic [4:0]      alu_shamt;
  logic [XLEN-1:0] alu_out;
  logic            alu_cf;

  modport master (
    output start, kill, op, rs1, rs2, alu_gnt, alu_out, alu_cf,
    input  busy, done, result, alu_req, alu_a, alu_b, alu_fn, alu_shamt
  );

  modport slave (
    input  start, kill, op, rs1, rs2, alu_gnt, alu_out, alu_cf,
    output busy, done, result, alu_req, alu_a, alu_b, alu_fn, alu_shamt
  );

endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer that borrows the core's shared ALU,
// iterating 32 shift-add / restoring-subtract steps on granted cycles.
module muldiv_seq
  import muldiv_pkg::*;
(
  input logic      clk,
  input logic      rst,
  muldiv_seq_if.slave bus
);

  logic [2:0]       state, state_n;
  logic [2:0]       op_q, op_n;
  logic [XLEN-1:0]  hi, hi_n;       // product high word / partial remainder
  logic [XLEN-1:0]  lo, lo_n;       // multiplier->product low / dividend->quotient
  logic [XLEN-1:0]  dsr, dsr_n;     // multiplicand / divisor magnitude
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             neg_q, neg_n;
  logic [XLEN-1:0]  result_q, result_n;
  logic             done_q, done_n;
  logic             busy_q, busy_n;
  logic             req_q, req_n;

  logic [XLEN-1:0]  alu_a_c, alu_b_c;
  logic [3:0]       alu_fn_c;

  logic             s1, s2;
  logic             div_zero, div_ovf;
  logic [XLEN-1:0]  r_sh, mul_s, hi_neg;
  logic             qbit, mul_c;

  assign s1       = rs1_signed(bus.op) & bus.rs1[XLEN-1];
  assign s2       = rs2_signed(bus.op) & bus.rs2[XLEN-1];
  assign div_zero = bus.op[2] && (bus.rs2 == '0);
  assign div_ovf  = bus.op[2] && !bus.op[0] && (bus.rs1 == INT_MIN) && (bus.rs2 == '1);

  // Restoring divide step: shifted remainder and quotient bit (m | no-borrow)
  assign r_sh = {hi[XLEN-2:0], lo[XLEN-1]};
  assign qbit = hi[XLEN-1] | bus.alu_cf;

  // Shift-add step: conditional accumulate with carry-out
  assign mul_c = lo[0] & bus.alu_cf;
  assign mul_s = lo[0] ? bus.alu_out : hi;

  // High word of a 64-bit negation; carry enters only when the low word is zero
  assign hi_neg = ~hi + XLEN'(lo == '0);

  always_comb begin
    state_n  = state;
    op_n     = op_q;
    hi_n     = hi;
    lo_n     = lo;
    dsr_n    = dsr;
    cnt_n    = cnt;
    neg_n    = neg_q;
    result_n = result_q;
    done_n   = 1'b0;
    alu_a_c  = '0;
    alu_b_c  = '0;
    alu_fn_c = ALU_ADD;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          op_n  = bus.op;
          lo_n  = bus.rs1;
          dsr_n = bus.rs2;
          hi_n  = '0;
          cnt_n = '0;
          neg_n = is_rem(bus.op) ? s1 : (s1 ^ s2);
          if (div_zero) begin
            result_n = is_rem(bus.op) ? bus.rs1 : '1;
            done_n   = 1'b1;
            state_n  = S_DONE;
          end else if (div_ovf) begin
            result_n = is_rem(bus.op) ? '0 : INT_MIN;
            done_n   = 1'b1;
            state_n  = S_DONE;
          end else begin
            state_n = S_PREP_A;
          end
        end
      end

      S_PREP_A: begin
        alu_fn_c = ALU_SUB;
        alu_b_c  = lo;
        if (bus.alu_gnt) begin
          if (rs1_signed(op_q) && lo[XLEN-1]) lo_n = bus.alu_out;
          state_n = S_PREP_B;
        end
      end

      S_PREP_B: begin
        alu_fn_c = ALU_SUB;
        alu_b_c  = dsr;
        if (bus.alu_gnt) begin
          if (rs2_signed(op_q) && dsr[XLEN-1]) dsr_n = bus.alu_out;
          cnt_n   = '0;
          state_n = S_LOOP;
        end
      end

      S_LOOP: begin
        alu_b_c = dsr;
        if (op_q[2]) begin
          alu_a_c  = r_sh;
          alu_fn_c = ALU_SUB;
        end else begin
          alu_a_c  = hi;
          alu_fn_c = ALU_ADD;
        end
        if (bus.alu_gnt) begin
          if (op_q[2]) begin
            hi_n = qbit ? bus.alu_out : r_sh;
            lo_n = {lo[XLEN-2:0], qbit};
          end else begin
            hi_n = {mul_c, mul_s[XLEN-1:1]};
            lo_n = {mul_s[0], lo[XLEN-1:1]};
          end
          cnt_n = cnt + CNT_W'(1);
          if (cnt == CNT_W'(XLEN - 1)) state_n = S_FIX;
        end
      end

      S_FIX: begin
        alu_fn_c = ALU_SUB;
        alu_b_c  = is_rem(op_q) ? hi : lo;
        if (bus.alu_gnt) begin
          if (is_mulhi(op_q)) result_n = neg_q ? hi_neg : hi;
          else                result_n = neg_q ? bus.alu_out : (is_rem(op_q) ? hi : lo);
          done_n  = 1'b1;
          state_n = S_DONE;
        end
      end

      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Abort wins over everything, including a same-cycle start or completion
    if (bus.kill) begin
      state_n  = S_IDLE;
      done_n   = 1'b0;
      result_n = result_q;
    end

    busy_n = (state_n != S_IDLE);
    req_n  = (state_n == S_PREP_A) || (state_n == S_PREP_B) ||
             (state_n == S_LOOP)   || (state_n == S_FIX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= '0;
      hi       <= '0;
      lo       <= '0;
      dsr      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      state    <= state_n;
      op_q     <= op_n;
      hi       <= hi_n;
      lo       <= lo_n;
      dsr      <= dsr_n;
      cnt      <= cnt_n;
      neg_q    <= neg_n;
      result_q <= result_n;
      done_q   <= done_n;
      busy_q   <= busy_n;
      req_q    <= req_n;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.alu_req   = req_q;
  assign bus.alu_a     = alu_a_c;
  assign bus.alu_b     = alu_b_c;
  assign bus.alu_fn    = alu_fn_c;
  assign bus.alu_shamt = '0;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: shared-ALU model, transaction-level reference
// model checked every cycle, plus directed literal cases and randomized traffic.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic chk_en = 1'b0;
  int   last_req_cnt;
  int   last_first_req;

  muldiv_seq_if bus();

  muldiv_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Shared ALU: ADD / SUB with carry (SUB carry = no borrow)
  logic [32:0] add_w;
  assign add_w       = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
  assign bus.alu_out = (bus.alu_fn == ALU_SUB) ? (bus.alu_a - bus.alu_b) : add_w[31:0];
  assign bus.alu_cf  = (bus.alu_fn == ALU_SUB) ? (bus.alu_a >= bus.alu_b) : add_w[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural RV32M result from 64-bit arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] ua, ub, up;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_MUL:    begin up = ua * ub; return up[31:0]; end
      OP_MULH:   begin sp = sa * sb; return sp[63:32]; end
      OP_MULHSU: begin sp = sa * $signed(ub); return sp[63:32]; end
      OP_MULHU:  begin up = ua * ub; return up[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        sp = sa / sb; return sp[31:0];
      end
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        sp = sa % sb; return sp[31:0];
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic is_special(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    return op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Transaction-level model: 35 granted ALU cycles then a done cycle, or done at once
  logic        m_busy, m_done, m_req;
  logic [31:0] m_res, m_pend;
  int          m_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_req <= 1'b0;
      m_res  <= '0;   m_pend <= '0;   m_left <= 0;
    end else if (bus.kill) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_req <= 1'b0; m_left <= 0;
    end else if (!m_busy) begin
      if (bus.start) begin
        m_busy <= 1'b1;
        if (is_special(bus.op, bus.rs1, bus.rs2)) begin
          m_done <= 1'b1;
          m_res  <= ref_res(bus.op, bus.rs1, bus.rs2);
          m_left <= 0;
        end else begin
          m_req  <= 1'b1;
          m_left <= 35;
          m_pend <= ref_res(bus.op, bus.rs1, bus.rs2);
        end
      end
    end else if (m_done) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
    end else if (bus.alu_gnt) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_req  <= 1'b0;
        m_res  <= m_pend;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc busy",   32'(bus.busy),    32'(m_busy));
      check("cyc done",   32'(bus.done),    32'(m_done));
      check("cyc alu_req",32'(bus.alu_req), 32'(m_req));
      check("cyc result", bus.result,       m_res);
      check("cyc shamt",  32'(bus.alu_shamt), 32'd0);
      if (bus.alu_req) check("cyc fn legal", 32'(bus.alu_fn inside {ALU_ADD, ALU_SUB}), 32'd1);
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // gmode: 0 grant always, 1 grant on even cycles after start, 2 random grant + start noise
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int gmode, input logic chk, input logic [31:0] exp_res,
                        input int exp_lat, input string name);
    int lat;
    logic [31:0] got;
    lat = 0; got = '0; last_req_cnt = 0; last_first_req = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = op; bus.rs1 = a; bus.rs2 = b; bus.alu_gnt = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      bus.alu_gnt = (gmode == 1) ? 1'(c % 2 == 0) :
                    (gmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (gmode == 2 && $urandom_range(0, 3) == 0) begin
        bus.start = 1'b1; bus.op = 3'($urandom); bus.rs1 = $urandom; bus.rs2 = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.alu_req) begin
        last_req_cnt++;
        if (last_first_req == 0) last_first_req = c;
      end
      if (bus.done) begin
        lat = c; got = bus.result;
        break;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.alu_gnt = 1'b1;
    check({name, " done seen"}, 32'(lat != 0), 32'd1);
    if (chk) begin
      check({name, " result"}, got, exp_res);
      check({name, " latency"}, 32'(lat), 32'(exp_lat));
    end
    if (lat == 0) begin
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
    end
  endtask

  initial begin
    int dcnt;
    rst = 1'b1;
    bus.start = 1'b0; bus.kill = 1'b0; bus.op = '0;
    bus.rs1 = '0; bus.rs2 = '0; bus.alu_gnt = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst busy",   32'(bus.busy),    32'd0);
    check("rst done",   32'(bus.done),    32'd0);
    check("rst result", bus.result,       32'd0);
    check("rst alu_req",32'(bus.alu_req), 32'd0);
    check("rst alu_a",  bus.alu_a,        32'd0);
    check("rst alu_b",  bus.alu_b,        32'd0);
    check("rst alu_fn", 32'(bus.alu_fn),  32'(ALU_ADD));
    chk_en = 1'b1;

    run_op(OP_MUL, 32'd7, 32'd6, 0, 1'b1, 32'd42, 36, "MUL 7x6");
    check("MUL req cycles", 32'(last_req_cnt), 32'd35);
    check("MUL first req",  32'(last_first_req), 32'd1);
    run_op(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 32'h0000_0000, 36, "MULH -1x-1");
    run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 32'hFFFF_FFFE, 36, "MULHU max");
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         0, 1'b1, 32'hFFFF_FFFF, 36, "MULHSU -1x2");
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 0, 1'b1, 32'hFFFF_FFFD, 36, "DIV -7/2");
    run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 0, 1'b1, 32'hFFFF_FFFF, 36, "REM -7/2");
    run_op(OP_DIVU, 32'd100, 32'd7, 0, 1'b1, 32'd14, 36, "DIVU 100/7");
    run_op(OP_REMU, 32'd100, 32'd7, 0, 1'b1, 32'd2,  36, "REMU 100/7");
    run_op(OP_DIVU, 32'd5, 32'd0, 0, 1'b1, 32'hFFFF_FFFF, 1, "DIVU 5/0");
    check("DIVU/0 no req", 32'(last_req_cnt), 32'd0);
    run_op(OP_REM,  32'd5, 32'd0, 0, 1'b1, 32'd5, 1, "REM 5/0");
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 32'h8000_0000, 1, "DIV ovf");
    check("DIV ovf no req", 32'(last_req_cnt), 32'd0);
    run_op(OP_MUL, 32'd3, 32'd5, 1, 1'b1, 32'd15, 71, "MUL 3x5 half-grant");

    // Abort at LOOP iteration 10: no done, result keeps 15
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = OP_MUL; bus.rs1 = 32'h1234; bus.rs2 = 32'h5678;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #1 bus.kill = 1'b1;
    @(posedge clk); #1 bus.kill = 1'b0;
    @(negedge clk);
    check("kill busy",   32'(bus.busy), 32'd0);
    check("kill done",   32'(bus.done), 32'd0);
    check("kill result", bus.result,    32'd15);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    check("kill no done", 32'(dcnt), 32'd0);

    // Reset in the middle of LOOP
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = OP_MUL; bus.rs1 = 32'hDEAD; bus.rs2 = 32'hBEEF;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid rst busy",   32'(bus.busy),      32'd0);
    check("mid rst done",   32'(bus.done),      32'd0);
    check("mid rst result", bus.result,         32'd0);
    check("mid rst req",    32'(bus.alu_req),   32'd0);
    check("mid rst alu_a",  bus.alu_a,          32'd0);
    check("mid rst alu_b",  bus.alu_b,          32'd0);
    check("mid rst alu_fn", 32'(bus.alu_fn),    32'(ALU_ADD));
    check("mid rst shamt",  32'(bus.alu_shamt), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    run_op(OP_DIVU, 32'd100, 32'd7, 0, 1'b1, 32'd14, 36, "DIVU after rst");

    for (int i = 0; i < 80; i++) begin
      run_op(3'($urandom), pick(), pick(), int'($urandom_range(0, 2)), 1'b0, '0, 0, "rand");
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for the RV32M multiply/divide instructions that reuses the core's shared 32-bit ALU instead of a dedicated multiplier or divider. It accepts one operation at a time from the execute stage and requests the ALU through a req/gnt pair owned by the pipeline. It drives the ALU's operand and function inputs, iterates 32 shift-add or restoring-subtract steps, and returns a 32-bit result with a one-cycle done pulse.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  launch an operation; sampled only when busy=0
- kill  in  1  abort; has priority over start
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1, rs2  in  32  operands, sampled with start
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; result valid
- result  out  32  final value; held until the next done
- alu_req  out  1  ALU wanted this cycle
- alu_gnt  in  1  pipeline grants the ALU this cycle
- alu_a, alu_b  out  32  ALU operands
- alu_fn  out  4  ALU function; only ADD=4'b0000 and SUB=4'b0001 are used
- alu_shamt  out  5  tied to 0
- alu_out  in  32  ALU result (combinational)
- alu_cf  in  1  ALU carry; for SUB, 1 means no borrow (a >= b unsigned)

## Operation
- States: IDLE, PREP_A, PREP_B, LOOP, FIX, DONE.
- IDLE: start=1 and kill=0 latches op, rs1, rs2 and raises busy.
  - DIV/DIVU/REM/REMU with rs2=0 go to DONE with quotient 0xFFFFFFFF or remainder rs1.
  - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF go to DONE with quotient 0x80000000 or remainder 0.
  - All other cases go to PREP_A.
- PREP_A / PREP_B: drive SUB with a=0 and b=operand.
  - If the operand is treated as signed and is negative, latch alu_out as its magnitude.
  - Otherwise keep the operand unchanged.
  - rs1 is signed for MULH, MULHSU, DIV and REM. rs2 is signed for MULH, DIV and REM.
  - Both states request the ALU even when no negation is needed, so latency is fixed.
- LOOP, multiply (counter 0..31), on each granted cycle:
  - ALU computes ADD hi + mcand.
  - If multiplier lsb=1, {c,hi} <= {alu_cf, alu_out}; else c=0.
  - Then {hi,lo} <= {c,hi,lo} >> 1.
  - The multiplier register occupies lo initially.
- LOOP, divide, on each granted cycle:
  - Form r' = {rem[30:0], dvd[31]} and remember the shifted-out bit rem[31] as m.
  - ALU computes SUB r' - divisor.
  - If m | alu_cf, then rem <= alu_out and the quotient bit is 1; else rem <= r' and the bit is 0.
  - dvd shifts left, taking in the quotient bit.
- FIX: negate the result if required; one granted SUB cycle (a=0).
  - Multiply: negate when the operand signs differ. The low word comes from the ALU; the high word is computed locally as ~hi + (lo==0).
  - Quotient: negate when the operand signs differ.
  - Remainder: takes the sign of rs1.
- Result selection: MUL gives lo; MULH/MULHSU/MULHU give hi; DIV/DIVU give the quotient; REM/REMU give the remainder.
- DONE: done=1 and result updates; next state is IDLE with busy=0.
- kill in any state: next state IDLE, busy=0, no done; result is unchanged.
- start while busy=1 is ignored.

## Timing
- Reset values: busy=0, done=0, result=0, alu_req=0, alu_a=0, alu_b=0, alu_fn=ADD, alu_shamt=0; state IDLE.
- alu_req=1 exactly in PREP_A, PREP_B, LOOP and FIX.
- A state advances, and its registers update, only on an edge where alu_gnt=1. Without a grant, all state holds.
- alu_a, alu_b and alu_fn are combinational from the registered state. alu_out and alu_cf are sampled on the same edge.
- With alu_gnt held at 1: done is high in the 36th cycle after the start edge (2 PREP + 32 LOOP + 1 FIX + DONE).
- Special cases: done is high in the cycle immediately after the start edge, and alu_req stays 0.
- Each cycle of grant withheld adds exactly one cycle of latency.
- Reset asserted mid-operation returns to the reset values immediately; no done is produced.

## Structure
- The shared package muldiv_pkg holds:
  - op codes (funct3 values);
  - ALU_ADD and ALU_SUB constants, matching the ALU's alufn encoding;
  - the state enumeration.
- Single module with no sub-module; the 6-bit iteration counter and the sign flags are local.

## Test plan
- MUL 7 × 6, grant always 1 -> done at cycle 36, result=42; alu_req high for cycles 1–35.
- MULH 0xFFFFFFFF × 0xFFFFFFFF -> result=0; MULHU same operands -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV −7 / 2 -> 0xFFFFFFFD; REM −7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5, each with done in the next cycle; DIV 0x80000000 / −1 -> 0x80000000 with alu_req never high.
- MUL 3 × 5 with alu_gnt low on every other cycle -> done at cycle 71, result=15.
- kill at LOOP iteration 10 -> busy=0 next cycle, no done, result keeps its old value; then reset mid-LOOP -> all outputs at reset values immediately, and a subsequent start works normally.
